// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM, control window (cycle count, halt/exit, status), power-up clear sweep.
// Latency: reads are combinational (zero cycles); writes commit on the next rising clock edge.
// Backpressure: none; the CPU has no stall path, and ready gates the CPU reset until the sweep completes.
module data_mem_responder #(
    parameter int          ADDR_BITS = 10,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_FFF0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_write_data,
    input  logic        i_mem_wr,
    output logic [31:0] o_mem_read_data,
    output logic        o_ready,
    output logic        o_halt,
    output logic [31:0] o_exit_code,
    output logic        o_addr_err
);

    localparam int                   DEPTH   = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] IDX_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

    // Control window register offsets, word granular (mem_addr[3:2])
    localparam logic [1:0] OFS_CYCLE  = 2'd0;
    localparam logic [1:0] OFS_EXIT   = 2'd1;
    localparam logic [1:0] OFS_STATUS = 2'd2;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t                 r_state;
    logic [ADDR_BITS-1:0]   r_clear_idx;
    logic                   r_ready;
    logic                   r_halt;
    logic [31:0]            r_exit_code;
    logic                   r_addr_err;
    logic [31:0]            r_cycle_count;
    logic [31:0]            r_mem [0:DEPTH-1];

    logic [ADDR_BITS-1:0]   w_word_idx;
    logic                   w_ram_hit;
    logic                   w_mmio_hit;
    logic [1:0]             w_mmio_ofs;
    logic                   w_running;
    logic                   w_ram_we;
    logic [31:0]            w_mmio_rdata;
    logic [31:0]            w_read_data;
    logic                   w_unused_addr;

    // Byte offset within a word carries no meaning for a word-organised RAM
    assign w_unused_addr = ^i_mem_addr[1:0];

    assign w_word_idx = i_mem_addr[ADDR_BITS+1:2];
    assign w_ram_hit  = (i_mem_addr[31:ADDR_BITS+2] == '0);
    assign w_mmio_hit = (i_mem_addr[31:4] == MMIO_BASE[31:4]);
    assign w_mmio_ofs = i_mem_addr[3:2];

    // CPU traffic only counts once the sweep has finished
    assign w_running = (r_state == S_READY);

    // A halted machine keeps its RAM frozen so software state can be inspected
    assign w_ram_we = w_running && i_mem_wr && w_ram_hit && !r_halt;

    // Control FSM: clear sweep, then normal operation with control-window side effects
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state       <= S_CLEAR;
            r_clear_idx   <= '0;
            r_ready       <= 1'b0;
            r_halt        <= 1'b0;
            r_exit_code   <= '0;
            r_addr_err    <= 1'b0;
            r_cycle_count <= '0;
        end else if (r_state == S_CLEAR) begin
            // Sweep one word per cycle; the last index hands over to READY
            r_clear_idx <= r_clear_idx + IDX_ONE;
            if (&r_clear_idx) begin
                r_state <= S_READY;
                r_ready <= 1'b1;
            end
        end else begin
            // Free-running cycle counter, frozen on halt, wraps naturally
            if (!r_halt) begin
                r_cycle_count <= r_cycle_count + 32'd1;
            end
            if (i_mem_wr) begin
                if (w_mmio_hit) begin
                    if (w_mmio_ofs == OFS_EXIT) begin
                        r_exit_code <= i_mem_write_data;
                        r_halt      <= 1'b1;
                    end else if (w_mmio_ofs == OFS_STATUS && i_mem_write_data[1]) begin
                        r_addr_err <= 1'b0;
                    end
                end else if (!w_ram_hit) begin
                    // Stores that land nowhere are latched for software to inspect
                    r_addr_err <= 1'b1;
                end
            end
        end
    end

    // Data RAM: sweep writes zeros, otherwise accepts full-word CPU stores (no reset on the array)
    always_ff @(posedge i_clk) begin
        if (r_state == S_CLEAR) begin
            r_mem[r_clear_idx] <= '0;
        end else if (w_ram_we) begin
            r_mem[w_word_idx] <= i_mem_write_data;
        end
    end

    // Control window read mux
    always_comb begin
        w_mmio_rdata = '0;
        case (w_mmio_ofs)
            OFS_CYCLE:  w_mmio_rdata = r_cycle_count;
            OFS_EXIT:   w_mmio_rdata = r_exit_code;
            OFS_STATUS: w_mmio_rdata = {30'b0, r_addr_err, r_halt};
            default:    w_mmio_rdata = '0;
        endcase
    end

    // Combinational read path; no bypass, so a same-cycle store shows up next cycle
    always_comb begin
        w_read_data = '0;
        if (w_running) begin
            if (w_ram_hit) begin
                w_read_data = r_mem[w_word_idx];
            end else if (w_mmio_hit) begin
                w_read_data = w_mmio_rdata;
            end
        end
    end

    assign o_mem_read_data = w_read_data;
    assign o_ready         = r_ready;
    assign o_halt          = r_halt;
    assign o_exit_code     = r_exit_code;
    assign o_addr_err      = r_addr_err;

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the CPU's data-memory interface: accepts the pipeline's mem_addr / mem_write_data / mem_wr and returns mem_read_data.
- Holds a word-organised data RAM, a small memory-mapped control window (cycle counter, halt/exit code, status) and a power-up clear sequencer.
- The pipeline has no stall path, so reads are combinational and writes commit at the clock edge.
- The top level holds the CPU in reset until ready is high.

Parameters:
ADDR_BITS, 10, log2 of RAM depth in 32-bit words (depth = 2^ADDR_BITS).
MMIO_BASE, 32'hFFFF_FFF0, byte address of the control window (16-byte aligned).

Ports:
clk  in  1  system clock, all state on rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset asserted).
mem_addr  in  32  byte address from CPU MEM stage.
mem_write_data  in  32  store data, already size-formatted by the CPU store filter.
mem_wr  in  1  write strobe for the current cycle.
mem_read_data  out  32  combinational read data for mem_addr.
ready  out  1  high once the clear sweep is complete.
halt  out  1  sticky halt flag, set by a software write.
exit_code  out  32  value written with the halt request.
addr_err  out  1  sticky out-of-range write error.

Behaviour:
- Addressing:
  - word index = mem_addr[ADDR_BITS+1:2]; mem_addr[1:0] is ignored.
  - RAM hit when mem_addr[31:ADDR_BITS+2] == 0.
  - MMIO hit when mem_addr[31:4] == MMIO_BASE[31:4].
- MMIO map (offsets):
  - +0x0 cycle_count (read-only).
  - +0x4 exit_code (write sets halt).
  - +0x8 status = {30'b0, addr_err, halt}; writing bit1 = 1 clears addr_err.
  - +0xC reads 0; writes are ignored.
- Reset (reset == 0, asynchronous):
  - state = CLEAR, clear_idx = 0.
  - ready = 0, halt = 0, exit_code = 0, addr_err = 0, cycle_count = 0.
  - RAM contents are not reset directly; the sweep zeroes them.
- FSM, two states:
  - CLEAR: each cycle writes 0 to RAM[clear_idx] and increments clear_idx. After writing index 2^ADDR_BITS-1, go to READY. ready rises exactly 2^ADDR_BITS cycles after reset deasserts.
  - READY: normal operation; no exit except reset.
- During CLEAR:
  - mem_wr is ignored entirely: no RAM write, no MMIO effect, no addr_err.
  - mem_read_data = 0.
- Reads (READY, combinational, zero latency):
  - RAM hit returns RAM[index].
  - MMIO hit returns the register per the map above.
  - Any other address returns 0 and never sets addr_err, since the CPU drives mem_addr every cycle.
- Writes (READY, mem_wr = 1, commit on rising edge):
  - RAM hit and halt = 0: full 32-bit word written. When halt = 1, RAM writes are dropped so state is frozen for inspection.
  - MMIO +0x4: exit_code <= mem_write_data, halt <= 1. A later write updates exit_code again; halt stays 1.
  - MMIO +0x8 with data bit1 = 1: addr_err <= 0.
  - Neither RAM nor MMIO hit: addr_err <= 1 (sticky).
- Read-during-write, same address: mem_read_data shows the old value in that cycle and the new value from the next cycle. No internal bypass.
- cycle_count:
  - Increments by 1 every cycle in READY while halt = 0.
  - Wraps from 32'hFFFF_FFFF to 0.
  - Frozen once halt = 1.
  - Reads at +0x0 return the pre-increment value of the current cycle.
- Reset asserted mid-sweep or mid-run: the sweep restarts from index 0 and every output returns to its reset value immediately.

Test Plan:
1. ADDR_BITS=4: release reset with mem_wr=1 at addr 0x4 -> ready low for exactly 16 cycles, then high; reading addr 0x4 returns 0; addr_err=0.
2. After ready: write 0xDEADBEEF to 0x8, read 0x8 same cycle -> old value 0; next cycle -> 0xDEADBEEF; read 0xA -> 0xDEADBEEF (low bits ignored).
3. After ready: write 0x1 to 0x40 (out of range, ADDR_BITS=4) -> addr_err=1; read 0xFFFF_FFF8 -> 0x2; write 0x2 to 0xFFFF_FFF8 -> addr_err=0.
4. Read 0xFFFF_FFF0 on two consecutive cycles -> values differ by 1; write 0x2A to 0xFFFF_FFF4 -> halt=1, exit_code=0x2A, counter frozen on later reads.
5. With halt=1, write 0x5 to 0x0 -> RAM[0] still reads its prior value.
6. Assert reset midway through a run and during the CLEAR sweep -> outputs go to reset values immediately; ready rises 16 cycles after release; previously written words read 0.
